dm_abstract_cmd: RTL and testbench
==================================

DM_ABSTRACT_CMD -- requirements
Module: dm_abstract_cmd

Interface
REQ-001 SHALL have parameter: GPR_BASE, 16'h1000, regno of x0; x0..x31 map to GPR_BASE..GPR_BASE+31.
REQ-002 SHALL have port: clk_i  in  1  single clock; all state on posedge.
REQ-003 SHALL have port: rst_ni  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: cmd_valid_i  in  1  one-cycle command write strobe.
REQ-005 SHALL have port: cmd_i  in  32  abstract command: cmdtype[31:24], aarsize[22:20], transfer[17], write[16], regno[15:0]; other bits ignored.
REQ-006 SHALL have port: data0_wr_en_i  in  1  debugger write to data0.
REQ-007 SHALL have port: data0_wr_data_i  in  32  data0 write value.
REQ-008 SHALL have port: cmderr_clr_i  in  1  clears cmderr.
REQ-009 SHALL have port: halted_i  in  1  hart halted status.
REQ-010 SHALL have port: data0_o  out  32  data0 register.
REQ-011 SHALL have port: busy_o  out  1  command in progress.
REQ-012 SHALL have port: cmderr_o  out  3  sticky error code.
REQ-013 SHALL have port: done_o  out  1  one-cycle completion pulse.
REQ-014 SHALL have port: dm_reg_rd_wr_en_o  out  1  GPR access enable.
REQ-015 SHALL have port: dm_reg_rd_wr_o  out  1  1 = write, 0 = read.
REQ-016 SHALL have port: dm_reg_rd_wr_address_o  out  16  register number.
REQ-017 SHALL have port: dm_reg_rd_wr_data_io  inout  32  shared data bus; driven only on write, else high-Z.
REQ-018 SHALL have port: DSP_reg_access_o  out  1  debug-mode register access qualifier.

Function
REQ-019 SHALL implement FSM IDLE -> CHECK -> ACCESS -> DONE -> IDLE; CHECK may go directly to DONE.
REQ-020 IDLE: cmd_valid_i with cmderr_o==0 SHALL latch cmd_i and enter CHECK; with cmderr_o!=0 the command SHALL be ignored.
REQ-021 CHECK, first failing rule wins: cmdtype!=0 or aarsize!=2 -> cmderr 2; transfer==0 -> DONE, no error; halted_i==0 -> cmderr 4; regno outside GPR_BASE..GPR_BASE+31 -> cmderr 3; else ACCESS. Error paths go to DONE.
REQ-022 ACCESS SHALL last exactly one cycle with en=1, DSP_reg_access_o=1, rd_wr=write bit, address=regno.
REQ-023 Write ACCESS SHALL drive data0_o onto the bus that cycle only. Read ACCESS SHALL tristate the bus and load data0 from the bus at the closing edge.
REQ-024 Access strobes SHALL be 0 and the bus high-Z in every state other than ACCESS.
REQ-025 busy_o SHALL be 1 in CHECK, ACCESS and DONE. done_o SHALL be 1 in DONE only.
REQ-026 Latency: cmd_valid_i sampled at edge N -> CHECK N+1, ACCESS N+2, DONE N+3, IDLE N+4; error or no-transfer paths finish one cycle earlier.
REQ-027 cmd_valid_i or data0_wr_en_i while busy_o=1 SHALL set cmderr 1 if cmderr==0, and SHALL change nothing else.
REQ-028 data0_wr_en_i while idle SHALL load data0 at the next edge.
REQ-029 cmderr SHALL be sticky: first nonzero code holds until cmderr_clr_i. A new error in the same cycle as clr SHALL win.
REQ-030 Writes to regno GPR_BASE (x0) SHALL be issued normally; the GPR file discards them.

Reset
REQ-031 rst_ni low SHALL immediately force: state IDLE, data0_o=0, cmderr_o=0, busy_o=0, done_o=0, all access strobes 0, address 0, bus high-Z. This applies mid-ACCESS too.
REQ-032 The first edge after rst_ni rises SHALL accept commands.

Configuration
REQ-033 Macro DM_ABSCMD_WRITE_EN defined: register writes SHALL be supported per REQ-023.
REQ-034 Macro DM_ABSCMD_WRITE_EN undefined: a command with write=1 SHALL set cmderr 2 in CHECK, and the bus SHALL never be driven.

Verification
REQ-035 Halted, GPR x4=0x00000009, cmd 0x00221004 -> one ACCESS cycle with address 0x1004 and rd_wr=0; data0_o=0x00000009 at N+3; done_o pulse at N+3; cmderr 0.
REQ-036 Macro on, data0 write 0xDEADBEEF, cmd 0x0023100D -> bus=0xDEADBEEF in the ACCESS cycle only, rd_wr=1, high-Z otherwise.
REQ-037 Cmd 0x00221020 -> cmderr 3, no access strobe. Cmd 0x00321004 -> cmderr 2.
REQ-038 halted_i=0, cmd 0x00221004 -> cmderr 4, no access. A second cmd is ignored until cmderr_clr_i.
REQ-039 Second cmd_valid_i at N+1 -> cmderr 1, first command completes normally; cmderr_clr_i -> 0.
REQ-040 rst_ni low during ACCESS -> strobes 0 and bus Z immediately, busy_o=0. Macro off with cmd 0x0023100D -> cmderr 2.

Source files
------------

// File: rtl/dm_abstract_cmd.sv
// Debug-module abstract command engine: validates Access Register commands and performs one GPR access.
// Optional feature macro DM_ABSCMD_WRITE_EN enables register writes; without it write commands fail with cmderr 2.
module dm_abstract_cmd #(
   parameter logic [15:0] GPR_BASE = 16'h1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   input  logic [31:0] cmd_i,
   input  logic        data0_wr_en_i,
   input  logic [31:0] data0_wr_data_i,
   input  logic        cmderr_clr_i,
   input  logic        halted_i,
   output logic [31:0] data0_o,
   output logic        busy_o,
   output logic [2:0]  cmderr_o,
   output logic        done_o,
   output logic        dm_reg_rd_wr_en_o,
   output logic        dm_reg_rd_wr_o,
   output logic [15:0] dm_reg_rd_wr_address_o,
   inout  wire  [31:0] dm_reg_rd_wr_data_io,
   output logic        DSP_reg_access_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_ACCESS,
      S_DONE
   } state_e;

   typedef struct packed {
      logic [7:0]  cmdtype;
      logic [2:0]  aarsize;
      logic        transfer;
      logic        write;
      logic [15:0] regno;
   } cmd_t;

   localparam logic [2:0] ERR_NONE          = 3'd0;
   localparam logic [2:0] ERR_BUSY          = 3'd1;
   localparam logic [2:0] ERR_NOT_SUPPORTED = 3'd2;
   localparam logic [2:0] ERR_EXCEPTION     = 3'd3;
   localparam logic [2:0] ERR_HALT_RESUME   = 3'd4;

   state_e      state_q;
   cmd_t        cmd_q;
   logic [15:0] regno_off;
   logic        regno_in_range;
   logic        write_blocked;
   logic        chk_go;
   logic [2:0]  chk_err;
   logic        busy_hit;
   logic [2:0]  err_new;
   logic        unused_cmd_bits;
`ifdef DM_ABSCMD_WRITE_EN
   logic        drive_q;
`endif

   assign unused_cmd_bits = ^{cmd_i[23], cmd_i[19:18]};

   // Offset compare keeps the range test correct even if GPR_BASE sits near the top of regno space.
   assign regno_off      = cmd_q.regno - GPR_BASE;
   assign regno_in_range = (regno_off[15:5] == 11'd0);

`ifdef DM_ABSCMD_WRITE_EN
   assign write_blocked = 1'b0;
`else
   assign write_blocked = cmd_q.write;
`endif

   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      chk_err = ERR_NONE;
      chk_go  = 1'b0;
      if (cmd_q.cmdtype != 8'd0 || cmd_q.aarsize != 3'd2 || write_blocked) begin
         chk_err = ERR_NOT_SUPPORTED;
      end else if (!cmd_q.transfer) begin
         chk_err = ERR_NONE;
      end else if (!halted_i) begin
         chk_err = ERR_HALT_RESUME;
      end else if (!regno_in_range) begin
         chk_err = ERR_EXCEPTION;
      end else begin
         chk_go = 1'b1;
      end
   end

   // A command check error outranks a simultaneous busy violation.
   assign busy_hit = busy_o & (cmd_valid_i | data0_wr_en_i);
   assign err_new  = (state_q == S_CHECK && chk_err != ERR_NONE) ? chk_err :
                     (busy_hit ? ERR_BUSY : ERR_NONE);

`ifdef DM_ABSCMD_WRITE_EN
   assign dm_reg_rd_wr_data_io = drive_q ? data0_o : 32'bz;
`else
   assign dm_reg_rd_wr_data_io = 32'bz;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q                <= S_IDLE;
         cmd_q                  <= '0;
         data0_o                <= '0;
         cmderr_o               <= ERR_NONE;
         busy_o                 <= 1'b0;
         done_o                 <= 1'b0;
         dm_reg_rd_wr_en_o      <= 1'b0;
         dm_reg_rd_wr_o         <= 1'b0;
         dm_reg_rd_wr_address_o <= '0;
         DSP_reg_access_o       <= 1'b0;
`ifdef DM_ABSCMD_WRITE_EN
         drive_q                <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
         if (err_new != ERR_NONE && (cmderr_o == ERR_NONE || cmderr_clr_i)) begin
            cmderr_o <= err_new;
         end else if (cmderr_clr_i) begin
            cmderr_o <= ERR_NONE;
         end

         case (state_q)
            S_IDLE: begin
               if (data0_wr_en_i) begin
                  data0_o <= data0_wr_data_i;
               end
               if (cmd_valid_i && cmderr_o == ERR_NONE) begin
                  cmd_q   <= {cmd_i[31:24], cmd_i[22:20], cmd_i[17], cmd_i[16], cmd_i[15:0]};
                  state_q <= S_CHECK;
                  busy_o  <= 1'b1;
               end
            end

            S_CHECK: begin
               if (chk_go) begin
                  state_q                <= S_ACCESS;
                  dm_reg_rd_wr_en_o      <= 1'b1;
                  DSP_reg_access_o       <= 1'b1;
                  dm_reg_rd_wr_o         <= cmd_q.write;
                  dm_reg_rd_wr_address_o <= cmd_q.regno;
`ifdef DM_ABSCMD_WRITE_EN
                  drive_q                <= cmd_q.write;
`endif
               end else begin
                  state_q <= S_DONE;
                  done_o  <= 1'b1;
               end
            end

            S_ACCESS: begin
               if (!dm_reg_rd_wr_o) begin
                  data0_o <= dm_reg_rd_wr_data_io;
               end
               state_q                <= S_DONE;
               done_o                 <= 1'b1;
               dm_reg_rd_wr_en_o      <= 1'b0;
               DSP_reg_access_o       <= 1'b0;
               dm_reg_rd_wr_o         <= 1'b0;
               dm_reg_rd_wr_address_o <= '0;
`ifdef DM_ABSCMD_WRITE_EN
               drive_q                <= 1'b0;
`endif
            end

            S_DONE: begin
               state_q <= S_IDLE;
               done_o  <= 1'b0;
               busy_o  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Directed self-checking bench for dm_abstract_cmd; a small GPR model answers read accesses on the shared bus.
module tb_dm_abstract_cmd;

   localparam logic [15:0] GPR_BASE = 16'h1000;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        cmd_valid_i;
   logic [31:0] cmd_i;
   logic        data0_wr_en_i;
   logic [31:0] data0_wr_data_i;
   logic        cmderr_clr_i;
   logic        halted_i;
   logic [31:0] data0_o;
   logic        busy_o;
   logic [2:0]  cmderr_o;
   logic        done_o;
   logic        dm_reg_rd_wr_en_o;
   logic        dm_reg_rd_wr_o;
   logic [15:0] dm_reg_rd_wr_address_o;
   logic        DSP_reg_access_o;
   tri   [31:0] bus;

   logic [31:0] gpr [0:31];
   logic        tb_drive;
   logic [31:0] tb_bus_val;
   integer      tests_run = 0;
   integer      tests_failed = 0;

   // {busy, done, en, rd_wr, dsp}
   wire  [4:0]  status = {busy_o, done_o, dm_reg_rd_wr_en_o, dm_reg_rd_wr_o, DSP_reg_access_o};

   dm_abstract_cmd #(.GPR_BASE(GPR_BASE)) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .cmd_valid_i           (cmd_valid_i),
      .cmd_i                 (cmd_i),
      .data0_wr_en_i         (data0_wr_en_i),
      .data0_wr_data_i       (data0_wr_data_i),
      .cmderr_clr_i          (cmderr_clr_i),
      .halted_i              (halted_i),
      .data0_o               (data0_o),
      .busy_o                (busy_o),
      .cmderr_o              (cmderr_o),
      .done_o                (done_o),
      .dm_reg_rd_wr_en_o     (dm_reg_rd_wr_en_o),
      .dm_reg_rd_wr_o        (dm_reg_rd_wr_o),
      .dm_reg_rd_wr_address_o(dm_reg_rd_wr_address_o),
      .dm_reg_rd_wr_data_io  (bus),
      .DSP_reg_access_o      (DSP_reg_access_o)
   );

   always #5 clk_i = ~clk_i;

   // Bench holds the bus at 0 outside write accesses, so any stray DUT drive of data0 shows up.
   always_comb begin
      tb_drive   = 1'b1;
      tb_bus_val = 32'h0;
      if (dm_reg_rd_wr_en_o && !dm_reg_rd_wr_o) tb_bus_val = gpr[dm_reg_rd_wr_address_o[4:0]];
      if (dm_reg_rd_wr_en_o && dm_reg_rd_wr_o) tb_drive = 1'b0;
   end
   assign bus = tb_drive ? tb_bus_val : 32'bz;

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue_cmd(input logic [31:0] c);
      cmd_i       = c;
      cmd_valid_i = 1'b1;
      step();
      cmd_valid_i = 1'b0;
   endtask

   task automatic clear_err();
      cmderr_clr_i = 1'b1;
      step();
      cmderr_clr_i = 1'b0;
   endtask

   task automatic load_data0(input logic [31:0] v);
      data0_wr_en_i   = 1'b1;
      data0_wr_data_i = v;
      step();
      data0_wr_en_i   = 1'b0;
   endtask

   task automatic test_reset();
      tests_run++; if (status !== 5'b00000) begin tests_failed++; $display("FAIL reset_status: got %b want %b", status, 5'b00000); end
      tests_run++; if (cmderr_o !== 3'd0) begin tests_failed++; $display("FAIL reset_cmderr: got %0d want 0", cmderr_o); end
      tests_run++; if (data0_o !== 32'h0) begin tests_failed++; $display("FAIL reset_data0: got %h want 0", data0_o); end
      tests_run++; if (dm_reg_rd_wr_address_o !== 16'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", dm_reg_rd_wr_address_o); end
   endtask

   task automatic test_data0_load();
      load_data0(32'h1234_5678);
      tests_run++; if (data0_o !== 32'h1234_5678) begin tests_failed++; $display("FAIL data0_load: got %h want 12345678", data0_o); end
   endtask

   task automatic test_gpr_read();
      issue_cmd(32'h0022_1004);
      tests_run++; if (status !== 5'b10000) begin tests_failed++; $display("FAIL read_check_state: got %b want 10000", status); end
      step();
      tests_run++; if (status !== 5'b10101) begin tests_failed++; $display("FAIL read_access_state: got %b want 10101", status); end
      tests_run++; if (dm_reg_rd_wr_address_o !== 16'h1004) begin tests_failed++; $display("FAIL read_access_addr: got %h want 1004", dm_reg_rd_wr_address_o); end
      tests_run++; if (data0_o !== 32'h1234_5678) begin tests_failed++; $display("FAIL read_data0_early: got %h want 12345678", data0_o); end
      step();
      tests_run++; if (status !== 5'b11000) begin tests_failed++; $display("FAIL read_done_state: got %b want 11000", status); end
      tests_run++; if (data0_o !== 32'h0000_0009) begin tests_failed++; $display("FAIL read_data0: got %h want 00000009", data0_o); end
      tests_run++; if (dm_reg_rd_wr_address_o !== 16'h0) begin tests_failed++; $display("FAIL read_done_addr: got %h want 0", dm_reg_rd_wr_address_o); end
      step();
      tests_run++; if (status !== 5'b00000) begin tests_failed++; $display("FAIL read_idle_state: got %b want 00000", status); end
      tests_run++; if (cmderr_o !== 3'd0) begin tests_failed++; $display("FAIL read_cmderr: got %0d want 0", cmderr_o); end
   endtask

   task automatic test_write_cmd();
      load_data0(32'hDEAD_BEEF);
      issue_cmd(32'h0023_100D);
      tests_run++; if (status !== 5'b10000) begin tests_failed++; $display("FAIL write_check_state: got %b want 10000", status); end
      tests_run++; if (bus !== 32'h0) begin tests_failed++; $display("FAIL write_check_bus: got %h want undriven", bus); end
`ifdef DM_ABSCMD_WRITE_EN
      step();
      tests_run++; if (status !== 5'b10111) begin tests_failed++; $display("FAIL write_access_state: got %b want 10111", status); end
      tests_run++; if (dm_reg_rd_wr_address_o !== 16'h100D) begin tests_failed++; $display("FAIL write_access_addr: got %h want 100d", dm_reg_rd_wr_address_o); end
      tests_run++; if (bus !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL write_access_bus: got %h want deadbeef", bus); end
      step();
      tests_run++; if (status !== 5'b11000) begin tests_failed++; $display("FAIL write_done_state: got %b want 11000", status); end
      tests_run++; if (bus !== 32'h0) begin tests_failed++; $display("FAIL write_done_bus: got %h want undriven", bus); end
      tests_run++; if (data0_o !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL write_data0: got %h want deadbeef", data0_o); end
      step();
      tests_run++; if (cmderr_o !== 3'd0) begin tests_failed++; $display("FAIL write_cmderr: got %0d want 0", cmderr_o); end
`else
      step();
      tests_run++; if (status !== 5'b11000) begin tests_failed++; $display("FAIL nowrite_done_state: got %b want 11000", status); end
      tests_run++; if (cmderr_o !== 3'd2) begin tests_failed++; $display("FAIL nowrite_cmderr: got %0d want 2", cmderr_o); end
      tests_run++; if (bus !== 32'h0) begin tests_failed++; $display("FAIL nowrite_bus: got %h want undriven", bus); end
      step();
      tests_run++; if (status !== 5'b00000) begin tests_failed++; $display("FAIL nowrite_idle_state: got %b want 00000", status); end
      clear_err();
      tests_run++; if (cmderr_o !== 3'd0) begin tests_failed++; $display("FAIL nowrite_clr: got %0d want 0", cmderr_o); end
`endif
   endtask

   task automatic test_bad_commands();
      issue_cmd(32'h0022_1020);
      step();
      tests_run++; if (status !== 5'b11000) begin tests_failed++; $display("FAIL badreg_done_state: got %b want 11000", status); end
      tests_run++; if (cmderr_o !== 3'd3) begin tests_failed++; $display("FAIL badreg_cmderr: got %0d want 3", cmderr_o); end
      step();
      clear_err();
      issue_cmd(32'h0032_1004);
      step();
      tests_run++; if (cmderr_o !== 3'd2) begin tests_failed++; $display("FAIL badsize_cmderr: got %0d want 2", cmderr_o); end
      tests_run++; if (status !== 5'b11000) begin tests_failed++; $display("FAIL badsize_done_state: got %b want 11000", status); end
      step();
      clear_err();
   endtask

   task automatic test_regno_bounds();
      logic [31:0] cmds [3]   = '{32'h0022_101F, 32'h0022_0FFF, 32'h0022_1000};
      logic [2:0]  errs [3]   = '{3'd0, 3'd3, 3'd0};
      logic        access [3] = '{1'b1, 1'b0, 1'b1};
      logic        seen;
      for (int i = 0; i < 3; i++) begin
         issue_cmd(cmds[i]);
         seen = 1'b0;
         for (int k = 0; k < 3; k++) begin
            step();
            seen |= dm_reg_rd_wr_en_o;
         end
         tests_run++; if (seen !== access[i]) begin tests_failed++; $display("FAIL bounds_access[%0d]: got %b want %b", i, seen, access[i]); end
         tests_run++; if (cmderr_o !== errs[i]) begin tests_failed++; $display("FAIL bounds_cmderr[%0d]: got %0d want %0d", i, cmderr_o, errs[i]); end
         clear_err();
      end
      tests_run++; if (data0_o !== 32'hA000_0000) begin tests_failed++; $display("FAIL bounds_x0_read: got %h want a0000000", data0_o); end
   endtask

   task automatic test_not_halted();
      halted_i = 1'b0;
      issue_cmd(32'h0022_1004);
      step();
      tests_run++; if (cmderr_o !== 3'd4) begin tests_failed++; $display("FAIL halt_cmderr: got %0d want 4", cmderr_o); end
      tests_run++; if (status !== 5'b11000) begin tests_failed++; $display("FAIL halt_done_state: got %b want 11000", status); end
      step();
      halted_i = 1'b1;
      gpr[4]   = 32'h0000_0055;
      issue_cmd(32'h0022_1004);
      tests_run++; if (status !== 5'b00000) begin tests_failed++; $display("FAIL halt_ignored_state: got %b want 00000", status); end
      tests_run++; if (cmderr_o !== 3'd4) begin tests_failed++; $display("FAIL halt_sticky: got %0d want 4", cmderr_o); end
      clear_err();
      tests_run++; if (cmderr_o !== 3'd0) begin tests_failed++; $display("FAIL halt_clr: got %0d want 0", cmderr_o); end
      issue_cmd(32'h0022_1004);
      tests_run++; if (status !== 5'b10000) begin tests_failed++; $display("FAIL halt_accept_state: got %b want 10000", status); end
      step();
      step();
      tests_run++; if (data0_o !== 32'h0000_0055) begin tests_failed++; $display("FAIL halt_retry_data0: got %h want 00000055", data0_o); end
      step();
   endtask

   task automatic test_no_transfer();
      issue_cmd(32'h0020_1004);
      tests_run++; if (status !== 5'b10000) begin tests_failed++; $display("FAIL notx_check_state: got %b want 10000", status); end
      step();
      tests_run++; if (status !== 5'b11000) begin tests_failed++; $display("FAIL notx_done_state: got %b want 11000", status); end
      step();
      tests_run++; if (status !== 5'b00000) begin tests_failed++; $display("FAIL notx_idle_state: got %b want 00000", status); end
      tests_run++; if (cmderr_o !== 3'd0 || data0_o !== 32'h0000_0055) begin tests_failed++; $display("FAIL notx_result: got err %0d data0 %h want 0 / 00000055", cmderr_o, data0_o); end
   endtask

   task automatic test_busy_error();
      gpr[4] = 32'h0000_0077;
      issue_cmd(32'h0022_1004);
      cmd_i       = 32'h0032_1004;
      cmd_valid_i = 1'b1;
      step();
      cmd_valid_i = 1'b0;
      tests_run++; if (status !== 5'b10101) begin tests_failed++; $display("FAIL busy_access_state: got %b want 10101", status); end
      tests_run++; if (cmderr_o !== 3'd1) begin tests_failed++; $display("FAIL busy_cmderr: got %0d want 1", cmderr_o); end
      data0_wr_en_i   = 1'b1;
      data0_wr_data_i = 32'hAAAA_AAAA;
      step();
      data0_wr_en_i   = 1'b0;
      tests_run++; if (data0_o !== 32'h0000_0077) begin tests_failed++; $display("FAIL busy_data0: got %h want 00000077", data0_o); end
      step();
      tests_run++; if (status !== 5'b00000 || cmderr_o !== 3'd1) begin tests_failed++; $display("FAIL busy_end: got %b err %0d want 00000 err 1", status, cmderr_o); end
      clear_err();
      tests_run++; if (cmderr_o !== 3'd0) begin tests_failed++; $display("FAIL busy_clr: got %0d want 0", cmderr_o); end
      issue_cmd(32'h0022_1004);
      data0_wr_en_i   = 1'b1;
      data0_wr_data_i = 32'h5555_5555;
      cmderr_clr_i    = 1'b1;
      step();
      data0_wr_en_i   = 1'b0;
      cmderr_clr_i    = 1'b0;
      tests_run++; if (cmderr_o !== 3'd1) begin tests_failed++; $display("FAIL clr_vs_new_err: got %0d want 1", cmderr_o); end
      step();
      step();
      clear_err();
   endtask

   task automatic test_reset_mid_access();
      issue_cmd(32'h0022_1004);
      step();
      tests_run++; if (status !== 5'b10101) begin tests_failed++; $display("FAIL rst_pre_access: got %b want 10101", status); end
      #2 rst_ni = 1'b0;
      #1;
      tests_run++; if (status !== 5'b00000) begin tests_failed++; $display("FAIL rst_mid_status: got %b want 00000", status); end
      tests_run++; if (dm_reg_rd_wr_address_o !== 16'h0 || data0_o !== 32'h0) begin tests_failed++; $display("FAIL rst_mid_regs: got addr %h data0 %h want 0 / 0", dm_reg_rd_wr_address_o, data0_o); end
      #1 rst_ni = 1'b1;
      issue_cmd(32'h0020_1004);
      tests_run++; if (status !== 5'b10000) begin tests_failed++; $display("FAIL rst_first_cmd: got %b want 10000", status); end
      step();
      step();
   endtask

   initial begin
      rst_ni          = 1'b0;
      cmd_valid_i     = 1'b0;
      cmd_i           = '0;
      data0_wr_en_i   = 1'b0;
      data0_wr_data_i = '0;
      cmderr_clr_i    = 1'b0;
      halted_i        = 1'b1;
      for (int i = 0; i < 32; i++) gpr[i] = 32'hA000_0000 + i;
      gpr[4] = 32'h0000_0009;
      repeat (2) @(posedge clk_i);
      #1;
      test_reset();
      rst_ni = 1'b1;
      test_data0_load();
      test_gpr_read();
      test_write_cmd();
      test_bad_commands();
      test_regno_bounds();
      test_not_halted();
      test_no_transfer();
      test_busy_error();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
